// File: rtl/ahblite_master_mux2_if.sv
// AHB-Lite address/data bundle for one port; master drives address and write data, slave returns ready and read data.
interface ahblite_master_mux2_if;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        input  HREADY, HRDATA
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        output HREADY, HRDATA
    );
endinterface

// File: rtl/ahblite_master_mux2.sv
// Two-master AHB-Lite mux, M1 over M0 with M0 starvation limit; zero added latency when uncontested.
// Losing master's address phase is captured and it is stalled (HREADY low) until the replay is accepted.
module ahblite_master_mux2 #(
    parameter int unsigned M0_STARVE_MAX = 4
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    ahblite_master_mux2_if.slave  m0,
    ahblite_master_mux2_if.slave  m1,
    ahblite_master_mux2_if.master bus,
    output logic                  HMASTER
);
    localparam logic [3:0] STARVE_MAX = 4'(M0_STARVE_MAX);

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
    } hdr_t;

    hdr_t       live [2];
    hdr_t       pend_hdr [2];
    hdr_t       sel_hdr;
    hdr_t       last_hdr;
    logic [1:0] pend;
    logic [1:0] rdy;
    logic [1:0] live_v;
    logic [1:0] req;
    logic       hold_v;
    logic       hold_id;
    logic       dvalid;
    logic       downer;
    logic [3:0] starve;
    logic       starve_hit;
    logic       gnt_v;
    logic       gnt_id;

    assign live[0] = {m0.HADDR, m0.HTRANS, m0.HWRITE, m0.HSIZE};
    assign live[1] = {m1.HADDR, m1.HTRANS, m1.HWRITE, m1.HSIZE};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rdy[i]    = pend[i] ? 1'b0 : (dvalid && downer == 1'(i)) ? bus.HREADY : 1'b1;
            live_v[i] = live[i].trans[1] & rdy[i];
        end
        req        = pend | live_v;
        starve_hit = req[0] && (starve == STARVE_MAX);
        // A stalled address phase must stay on the bus unchanged, so the held owner wins outright
        gnt_v      = hold_v | (|req);
        gnt_id     = hold_v ? hold_id : (req[1] & ~starve_hit);
        sel_hdr    = pend[gnt_id] ? pend_hdr[gnt_id] : live[gnt_id];
    end

    assign bus.HTRANS = (gnt_v && !HRESET) ? sel_hdr.trans : 2'b00;
    assign bus.HADDR  = gnt_v ? sel_hdr.addr  : last_hdr.addr;
    assign bus.HWRITE = gnt_v ? sel_hdr.write : last_hdr.write;
    assign bus.HSIZE  = gnt_v ? sel_hdr.size  : last_hdr.size;
    assign bus.HWDATA = downer ? m1.HWDATA : m0.HWDATA;
    assign HMASTER    = downer & ~HRESET;
    assign m0.HREADY  = rdy[0] | HRESET;
    assign m1.HREADY  = rdy[1] | HRESET;
    assign m0.HRDATA  = bus.HRDATA;
    assign m1.HRDATA  = bus.HRDATA;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            pend     <= '0;
            hold_v   <= 1'b0;
            hold_id  <= 1'b0;
            dvalid   <= 1'b0;
            downer   <= 1'b0;
            starve   <= '0;
            last_hdr <= '0;
            for (int i = 0; i < 2; i++) begin
                pend_hdr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (gnt_v && bus.HREADY && gnt_id == 1'(i)) begin
                    pend[i] <= 1'b0;
                end else if (live_v[i]) begin
                    pend[i]     <= 1'b1;
                    pend_hdr[i] <= live[i];
                end
            end
            hold_v  <= gnt_v & ~bus.HREADY;
            hold_id <= gnt_id;
            if (gnt_v) begin
                last_hdr <= sel_hdr;
            end
            if (bus.HREADY) begin
                dvalid <= gnt_v;
                if (gnt_v) begin
                    downer <= gnt_id;
                end
                if (gnt_v && gnt_id && req[0]) begin
                    starve <= (starve == STARVE_MAX) ? starve : starve + 4'd1;
                end else begin
                    starve <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_ahblite_master_mux2.sv
// Randomized and directed bench for ahblite_master_mux2 against a transaction-level model of the arbiter.
module tb_ahblite_master_mux2;
    localparam int STARVE_MAX = 4;
    localparam logic [1:0] IDLE = 2'b00, NS = 2'b10, SEQ = 2'b11;

    typedef struct {
        bit          v;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
    } xfer_t;

    logic HCLK = 1'b0;
    logic HRESET;
    logic HMASTER;
    always #5 HCLK = ~HCLK;

    ahblite_master_mux2_if m0();
    ahblite_master_mux2_if m1();
    ahblite_master_mux2_if bus();

    ahblite_master_mux2 #(.M0_STARVE_MAX(STARVE_MAX)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .m0(m0), .m1(m1), .bus(bus), .HMASTER(HMASTER)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Master-side view: what each master is presenting, and whether it may move on
    xfer_t       cur [2];
    logic [31:0] wd [2];
    bit          ok [2];
    logic [31:0] rdata;

    // Reference model: transfers a master believes issued but the bus has not taken yet
    xfer_t waiting [2];
    int    stuck_who;
    bit    dp_busy;
    int    owner;
    int    starve;

    logic [1:0]  obs_trans;
    logic [31:0] obs_addr;
    logic        obs_master, obs_hr0, obs_hr1;

    function automatic xfer_t mk(logic [1:0] t, logic [31:0] a, logic w, logic [2:0] s);
        xfer_t x;
        x.v = 1'b0; x.trans = t; x.addr = a; x.write = w; x.size = s;
        return x;
    endfunction

    function automatic xfer_t rnd_xfer();
        logic [1:0] t;
        int r = $urandom_range(0, 9);
        t = (r < 4) ? NS : (r < 6) ? SEQ : (r < 8) ? IDLE : 2'b01;
        return mk(t, $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 2)));
    endfunction

    task automatic model_reset();
        for (int x = 0; x < 2; x++) waiting[x].v = 1'b0;
        stuck_who = -1; dp_busy = 1'b0; owner = 0; starve = 0;
    endtask

    task automatic step(input bit rst, input xfer_t n0, input xfer_t n1, input bit hr);
        bit    hm [2];
        bit    issuing [2];
        bit    offer [2];
        int    win;
        xfer_t xf;
        if (ok[0]) begin cur[0] = n0; wd[0] = $urandom; end
        if (ok[1]) begin cur[1] = n1; wd[1] = $urandom; end
        m0.HADDR = cur[0].addr; m0.HTRANS = cur[0].trans; m0.HWRITE = cur[0].write;
        m0.HSIZE = cur[0].size; m0.HWDATA = wd[0];
        m1.HADDR = cur[1].addr; m1.HTRANS = cur[1].trans; m1.HWRITE = cur[1].write;
        m1.HSIZE = cur[1].size; m1.HWDATA = wd[1];
        HRESET = rst; bus.HREADY = hr; rdata = $urandom; bus.HRDATA = rdata;
        @(negedge HCLK);
        for (int x = 0; x < 2; x++) begin
            hm[x]      = waiting[x].v ? 1'b0 : (dp_busy && owner == x) ? hr : 1'b1;
            issuing[x] = (cur[x].trans == NS || cur[x].trans == SEQ) && hm[x];
            offer[x]   = waiting[x].v || issuing[x];
        end
        if (stuck_who >= 0)                                   win = stuck_who;
        else if (offer[1] && !(offer[0] && starve == STARVE_MAX)) win = 1;
        else if (offer[0])                                    win = 0;
        else                                                  win = -1;
        if (rst) begin
            check("rst_htrans", bus.HTRANS, IDLE);
            check("rst_hready_m0", m0.HREADY, 1);
            check("rst_hready_m1", m1.HREADY, 1);
            check("rst_hmaster", HMASTER, 0);
        end else begin
            if (win >= 0) begin
                xf = waiting[win].v ? waiting[win] : cur[win];
                check("htrans", bus.HTRANS, xf.trans);
                check("haddr", bus.HADDR, xf.addr);
                check("hwrite", bus.HWRITE, xf.write);
                check("hsize", bus.HSIZE, xf.size);
            end else begin
                check("htrans_idle", bus.HTRANS, IDLE);
            end
            check("hready_m0", m0.HREADY, hm[0]);
            check("hready_m1", m1.HREADY, hm[1]);
            check("hmaster", HMASTER, owner[0]);
            check("hwdata", bus.HWDATA, wd[owner]);
        end
        check("hrdata_m0", m0.HRDATA, rdata);
        check("hrdata_m1", m1.HRDATA, rdata);
        obs_trans = bus.HTRANS; obs_addr = bus.HADDR; obs_master = HMASTER;
        obs_hr0 = m0.HREADY; obs_hr1 = m1.HREADY;
        ok[0] = m0.HREADY; ok[1] = m1.HREADY;
        @(posedge HCLK);
        if (rst) begin
            model_reset();
        end else begin
            for (int x = 0; x < 2; x++) begin
                if (win == x && hr) waiting[x].v = 1'b0;
                else if (!waiting[x].v && issuing[x]) begin
                    waiting[x] = cur[x];
                    waiting[x].v = 1'b1;
                end
            end
            stuck_who = (win >= 0 && !hr) ? win : -1;
            if (hr) begin
                dp_busy = (win >= 0);
                if (win >= 0) owner = win;
                if (win == 1 && offer[0]) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
                else starve = 0;
            end
        end
        #1;
    endtask

    xfer_t idl;

    initial begin
        idl = mk(IDLE, 32'h0, 1'b0, 3'd0);
        cur[0] = idl; cur[1] = idl; wd[0] = '0; wd[1] = '0; ok[0] = 1'b1; ok[1] = 1'b1;
        HRESET = 1'b1; bus.HREADY = 1'b1; bus.HRDATA = '0;
        model_reset();
        @(posedge HCLK); #1;
        step(1, idl, idl, 1);
        step(1, idl, idl, 1);

        // Lone M0 read
        step(0, mk(NS, 32'h0000_0100, 0, 2), idl, 1);
        check("lone_addr", obs_addr, 32'h100);
        check("lone_trans", obs_trans, NS);
        check("lone_hr0", obs_hr0, 1);
        step(0, idl, idl, 1);
        check("lone_dp_hr0", obs_hr0, 1);
        step(0, idl, idl, 1);

        // Collision: M1 goes first, M0 stalled one cycle and replayed
        step(0, mk(NS, 32'h0000_0100, 0, 2), mk(NS, 32'h2000_0000, 1, 2), 1);
        check("coll_first_addr", obs_addr, 32'h2000_0000);
        step(0, idl, idl, 1);
        check("coll_replay_addr", obs_addr, 32'h100);
        check("coll_hr0_low", obs_hr0, 0);
        check("coll_hmaster_m1", obs_master, 1);
        step(0, idl, idl, 1);
        check("coll_hr0_back", obs_hr0, 1);
        check("coll_hmaster_m0", obs_master, 0);
        step(0, idl, idl, 1);

        // Wait states during an M1 write data phase while M0 requests
        step(0, idl, mk(NS, 32'h2000_0040, 1, 2), 1);
        for (int i = 0; i < 3; i++) begin
            step(0, mk(NS, 32'h0000_0300, 0, 2), idl, 0);
            check("ws_addr_stable", obs_addr, 32'h300);
            check("ws_trans_stable", obs_trans, NS);
            check("ws_hr1_low", obs_hr1, 0);
        end
        step(0, idl, idl, 1);
        check("ws_hr1_release", obs_hr1, 1);
        check("ws_m0_pending", obs_hr0, 0);
        step(0, idl, idl, 1);
        step(0, idl, idl, 1);

        // Starvation: four M1 grants, then M0 forced through
        for (int i = 0; i < 5; i++) begin
            step(0, mk(NS, 32'h0000_0500, 0, 2), mk(NS, 32'h1000 + 32'(4 * i), 1, 2), 1);
            if (i < 4) check("starve_m1_grant", obs_addr, 32'h1000 + 32'(4 * i));
            else       check("starve_m0_forced", obs_addr, 32'h500);
        end
        for (int i = 0; i < 4; i++) step(0, idl, idl, 1);

        // Reset while M0 is pending and the bus is stalled
        step(0, idl, mk(NS, 32'h2000_0080, 1, 2), 1);
        step(0, mk(NS, 32'h0000_0600, 0, 2), idl, 0);
        step(1, idl, idl, 0);
        step(0, idl, idl, 1);
        check("rst_noreplay_trans", obs_trans, IDLE);
        check("rst_after_hr0", obs_hr0, 1);
        check("rst_after_hr1", obs_hr1, 1);

        // M1 burst of four, no bubble
        for (int i = 0; i < 4; i++) begin
            step(0, idl, mk(i == 0 ? NS : SEQ, 32'h3000 + 32'(4 * i), 0, 2), 1);
            check("burst_trans", obs_trans, i == 0 ? NS : SEQ);
            check("burst_addr", obs_addr, 32'h3000 + 32'(4 * i));
        end
        step(0, idl, idl, 1);

        // Random traffic with random wait states and occasional reset
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 149) == 0, rnd_xfer(), rnd_xfer(), $urandom_range(0, 9) < 7);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
